spi_cmd_arbiter: RTL and testbench

SPI_CMD_ARBITER -- requirements
Module: spi_cmd_arbiter

---
 rtl/spi_pkg.sv | 28 ++
 rtl/spi_rr_arbiter.sv | 35 +++
 rtl/spi_cmd_arbiter.sv | 157 +++++++++++++++
 tb/tb_spi_cmd_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared widths, instruction field layout and arbiter state encoding for the
// SPI instruction path.
package spi_pkg;

    localparam int DWIDTH = 32;
    localparam int AWIDTH = 8;

    // Number of instruction requesters and instruction word width.
    localparam int NREQ  = 4;
    localparam int CMD_W = DWIDTH + AWIDTH + 5;

    // Field offsets inside an instruction word (LSB of each field).
    localparam int OFF_WDATA = 0;
    localparam int OFF_ADDR  = DWIDTH;
    localparam int OFF_SIZE  = DWIDTH + AWIDTH;
    localparam int OFF_WR    = OFF_SIZE + 2;
    localparam int OFF_SS    = OFF_WR + 1;

    // All-zero instruction used to close a session; it produces no response.
    localparam logic [CMD_W-1:0] CMD_NOP = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        CLOSE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Round-robin picker: the search starts at ptr_i and wraps N-1 -> 0; the
// first requester found wins.
module spi_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic found;
    int   pos;

    // Scan all requesters starting at the pointer; keep only the first hit.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        pos     = 0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(ptr_i) + k) % N;
            if (!found && req_i[pos]) begin
                found        = 1'b1;
                grant_o[pos] = 1'b1;
                idx_o        = IW'(pos);
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/spi_cmd_arbiter.sv
// Arbitrates instruction requesters onto a single SPI master, keeps the
// session open while work is queued and routes read data back to the
// requester whose read instruction the master consumed previously.
module spi_cmd_arbiter #(
    parameter int NREQ  = spi_pkg::NREQ,
    parameter int CMD_W = spi_pkg::CMD_W
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [1:0]                        cfg_mode,
    input  logic [NREQ-1:0]                   req_valid,
    input  logic [NREQ-1:0][CMD_W-1:0]        req_data,
    output logic [NREQ-1:0]                   req_ready,
    output logic [NREQ-1:0]                   rsp_valid,
    output logic [spi_pkg::DWIDTH-1:0]        rsp_data,
    input  logic                              driver_read,
    input  logic [spi_pkg::DWIDTH-1:0]        spi_slv_read_data,
    output logic                              master_en,
    output logic [CMD_W-1:0]                  driver_data,
    output logic [1:0]                        driver_cfg,
    output logic                              busy
);

    import spi_pkg::*;

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t        state_q, state_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;          // instruction on driver_data
    logic [IW-1:0]     owner_q, owner_d;      // requester that owns cmd_q
    logic [IW-1:0]     ptr_q, ptr_d;          // round-robin search start
    logic              rd_pend_q, rd_pend_d;  // consumed read awaiting data
    logic [IW-1:0]     rd_owner_q, rd_owner_d;
    logic              men_q, men_d;
    logic [1:0]        cfg_q, cfg_d;

    logic [NREQ-1:0]   grant;
    logic [IW-1:0]     win_idx;
    logic [IW-1:0]     ptr_next;
    logic              any_req;
    logic              accept;
    logic              rsp_fire;

    spi_rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (win_idx),
        .any_o   (any_req)
    );

    assign ptr_next = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);

    // Session FSM: decides acceptance, response delivery and next register values.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        rd_pend_d  = rd_pend_q;
        rd_owner_d = rd_owner_q;
        men_d      = men_q;
        cfg_d      = cfg_q;
        accept     = 1'b0;
        rsp_fire   = 1'b0;

        case (state_q)
            IDLE: begin
                men_d  = 1'b0;
                cmd_d  = '0;
                cfg_d  = cfg_mode;
                accept = any_req;
            end
            SERVE: begin
                if (driver_read) begin
                    // The master just took cmd_q; its read data arrives next consume.
                    rsp_fire   = rd_pend_q;
                    rd_pend_d  = ~cmd_q[OFF_WR];
                    rd_owner_d = owner_q;
                    if (any_req) begin
                        accept = 1'b1;
                    end else begin
                        cmd_d   = '0;
                        state_d = CLOSE;
                    end
                end
            end
            CLOSE: begin
                if (driver_read) begin
                    rsp_fire  = rd_pend_q;
                    rd_pend_d = 1'b0;
                end
                if (any_req) begin
                    accept = 1'b1;
                end else if (driver_read) begin
                    men_d   = 1'b0;
                    cmd_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            cmd_d   = req_data[win_idx];
            owner_d = win_idx;
            ptr_d   = ptr_next;
            men_d   = 1'b1;
            state_d = SERVE;
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= '0;
            men_q      <= 1'b0;
            cfg_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
            men_q      <= men_d;
            cfg_q      <= cfg_d;
        end
    end

    // One-hot response strobe towards the owner of the pending read.
    always_comb begin
        rsp_valid = '0;
        if (rsp_fire) begin
            rsp_valid[rd_owner_q] = 1'b1;
        end
    end

    // Acceptance is combinational, so it is masked while reset is held.
    assign req_ready   = (accept && rst_n) ? grant : '0;
    assign rsp_data    = rsp_fire ? spi_slv_read_data : '0;
    assign master_en   = men_q;
    assign driver_data = cmd_q;
    assign driver_cfg  = cfg_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Self-checking bench for spi_cmd_arbiter: cycle tables for single write/read
// sessions plus scoreboarded multi-instruction sequences.
module tb_spi_cmd_arbiter;

    localparam int NR = 4;
    localparam int CW = spi_pkg::CMD_W;
    localparam int DW = spi_pkg::DWIDTH;

    logic                     clk;
    logic                     rst_n;
    logic [1:0]               cfg_mode;
    logic [NR-1:0]            req_valid;
    logic [NR-1:0][CW-1:0]    req_data;
    logic [NR-1:0]            req_ready;
    logic [NR-1:0]            rsp_valid;
    logic [DW-1:0]            rsp_data;
    logic                     driver_read;
    logic [DW-1:0]            spi_slv_read_data;
    logic                     master_en;
    logic [CW-1:0]            driver_data;
    logic [1:0]               driver_cfg;
    logic                     busy;

    spi_cmd_arbiter #(.NREQ(NR), .CMD_W(CW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cfg_mode          (cfg_mode),
        .req_valid         (req_valid),
        .req_data          (req_data),
        .req_ready         (req_ready),
        .rsp_valid         (rsp_valid),
        .rsp_data          (rsp_data),
        .driver_read       (driver_read),
        .spi_slv_read_data (spi_slv_read_data),
        .master_en         (master_en),
        .driver_data       (driver_data),
        .driver_cfg        (driver_cfg),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Instruction words: {SS, WR_EN, SIZE, ADDR, WDATA}.
    logic [CW-1:0] cmds [NR];

    // Scoreboard queues.
    typedef struct {
        int          owner;
        logic [31:0] data;
    } rsp_t;

    int            grant_q [$];
    logic [CW-1:0] cmdexp_q[$];
    rsp_t          rsp_q   [$];
    logic          sb_en = 1'b0;

    // Monitor: every grant, consumed instruction and response is popped and compared.
    always @(negedge clk) begin
        if (sb_en && rst_n) begin
            if (req_ready != '0) begin
                if (grant_q.size() == 0) begin
                    check("grant_unexpected", 64'(req_ready), 64'd0);
                end else begin
                    logic [NR-1:0] g;
                    g = 4'b0001 << grant_q.pop_front();
                    check("grant", 64'(req_ready), 64'(g));
                end
            end
            if (driver_read && driver_data != '0) begin
                if (cmdexp_q.size() == 0) begin
                    check("cmd_unexpected", 64'(driver_data), 64'd0);
                end else begin
                    check("cmd_consumed", 64'(driver_data), 64'(cmdexp_q.pop_front()));
                end
            end
            if (rsp_valid != '0) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    rsp_t e;
                    logic [NR-1:0] v;
                    e = rsp_q.pop_front();
                    v = 4'b0001 << e.owner;
                    check("rsp_valid", 64'(rsp_valid), 64'(v));
                    check("rsp_data", 64'(rsp_data), 64'(e.data));
                end
            end
        end
    end

    task automatic drive(input logic [NR-1:0] rv, input logic dr, input logic [31:0] sd);
        req_valid         = rv;
        driver_read       = dr;
        spi_slv_read_data = sd;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        req_valid   = '0;
        driver_read = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_queues(input string nm);
        check({nm, "_grants_left"}, 64'(grant_q.size()), 64'd0);
        check({nm, "_cmds_left"}, 64'(cmdexp_q.size()), 64'd0);
        check({nm, "_rsps_left"}, 64'(rsp_q.size()), 64'd0);
    endtask

    typedef struct {
        logic [NR-1:0] rv;
        logic          dr;
        logic [31:0]   sd;
        logic [NR-1:0] ex_ready;
        logic [NR-1:0] ex_rsp;
        logic [31:0]   ex_rdata;
        logic          ex_men;
        logic [CW-1:0] ex_dd;
        logic          ex_busy;
    } vec_t;

    vec_t vecs [10];

    initial begin
        cmds[0] = {2'b00, 1'b1, 2'b10, 8'h10, 32'hA5A5_A5A5};
        cmds[1] = {2'b01, 1'b0, 2'b10, 8'h30, 32'h0};
        cmds[2] = {2'b10, 1'b0, 2'b10, 8'h20, 32'h0};
        cmds[3] = {2'b11, 1'b0, 2'b10, 8'h40, 32'h0};
        for (int i = 0; i < NR; i++) req_data[i] = cmds[i];

        // Single write from requester 0, then single read from requester 2.
        vecs[0] = '{4'b0001, 1'b0, 32'h0,         4'b0001, 4'b0000, 32'h0,         1'b0, '0,      1'b0};
        vecs[1] = '{4'b0000, 1'b0, 32'h0,         4'b0000, 4'b0000, 32'h0,         1'b1, cmds[0], 1'b1};
        vecs[2] = '{4'b0000, 1'b1, 32'h0,         4'b0000, 4'b0000, 32'h0,         1'b1, cmds[0], 1'b1};
        vecs[3] = '{4'b0000, 1'b0, 32'h0,         4'b0000, 4'b0000, 32'h0,         1'b1, '0,      1'b1};
        vecs[4] = '{4'b0000, 1'b1, 32'h0,         4'b0000, 4'b0000, 32'h0,         1'b1, '0,      1'b1};
        vecs[5] = '{4'b0000, 1'b0, 32'h0,         4'b0000, 4'b0000, 32'h0,         1'b0, '0,      1'b0};
        vecs[6] = '{4'b0100, 1'b0, 32'h0,         4'b0100, 4'b0000, 32'h0,         1'b0, '0,      1'b0};
        vecs[7] = '{4'b0000, 1'b1, 32'h1234_5678, 4'b0000, 4'b0000, 32'h0,         1'b1, cmds[2], 1'b1};
        vecs[8] = '{4'b0000, 1'b1, 32'hDEAD_BEEF, 4'b0000, 4'b0100, 32'hDEAD_BEEF, 1'b1, '0,      1'b1};
        vecs[9] = '{4'b0000, 1'b0, 32'h0,         4'b0000, 4'b0000, 32'h0,         1'b0, '0,      1'b0};

        cfg_mode          = 2'b00;
        spi_slv_read_data = '0;
        rst_n             = 1'b0;
        driver_read       = 1'b1;
        req_valid         = 4'hF;

        // Reset state with requests already asserted.
        #3;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_master_en", 64'(master_en), 64'd0);
        check("rst_driver_data", 64'(driver_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        do_reset();

        // Table: single write and single read sessions.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].rv, vecs[i].dr, vecs[i].sd);
            check($sformatf("vec%0d_req_ready", i), 64'(req_ready), 64'(vecs[i].ex_ready));
            check($sformatf("vec%0d_rsp_valid", i), 64'(rsp_valid), 64'(vecs[i].ex_rsp));
            if (vecs[i].ex_rsp != '0)
                check($sformatf("vec%0d_rsp_data", i), 64'(rsp_data), 64'(vecs[i].ex_rdata));
            check($sformatf("vec%0d_master_en", i), 64'(master_en), 64'(vecs[i].ex_men));
            check($sformatf("vec%0d_driver_data", i), 64'(driver_data), 64'(vecs[i].ex_dd));
            check($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].ex_busy));
            tick();
        end

        // Fairness: all requesters valid for 8 instructions, one grant per consume.
        do_reset();
        sb_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            grant_q.push_back(k % 4);
            cmdexp_q.push_back(cmds[k % 4]);
        end
        drive(4'hF, 1'b0, 32'h0);
        tick();
        for (int j = 0; j <= 8; j++) begin
            if (j > 0 && ((j - 1) % 4) != 0)
                rsp_q.push_back('{(j - 1) % 4, 32'h100 + 32'(j)});
            drive((j < 7) ? 4'hF : 4'h0, 1'b1, 32'h100 + 32'(j));
            check($sformatf("fair%0d_master_en", j), 64'(master_en), 64'd1);
            tick();
        end
        drive(4'h0, 1'b0, 32'h0);
        check("fair_end_master_en", 64'(master_en), 64'd0);
        check("fair_end_busy", 64'(busy), 64'd0);
        tick();
        check_queues("fair");

        // Interleaved reads from requesters 1 and 3.
        grant_q.push_back(1);
        grant_q.push_back(3);
        cmdexp_q.push_back(cmds[1]);
        cmdexp_q.push_back(cmds[3]);
        rsp_q.push_back('{1, 32'h11});
        rsp_q.push_back('{3, 32'h33});
        drive(4'b0010, 1'b0, 32'h0);  tick();
        drive(4'b1000, 1'b1, 32'h99); tick();
        drive(4'b0000, 1'b1, 32'h11); tick();
        drive(4'b0000, 1'b1, 32'h33); tick();
        drive(4'b0000, 1'b0, 32'h0);
        check("ilv_end_busy", 64'(busy), 64'd0);
        tick();
        check_queues("ilv");

        // Late request while the closing NOP is presented; also mode capture.
        cfg_mode = 2'b10;
        drive(4'b0000, 1'b0, 32'h0); tick();
        grant_q.push_back(0);
        grant_q.push_back(0);
        cmdexp_q.push_back(cmds[0]);
        cmdexp_q.push_back(cmds[0]);
        drive(4'b0001, 1'b0, 32'h0);
        check("late_cfg_idle", 64'(driver_cfg), 64'd2);
        tick();
        cfg_mode = 2'b01;
        drive(4'b0000, 1'b1, 32'h0);
        check("late_c1_master_en", 64'(master_en), 64'd1);
        tick();
        drive(4'b0001, 1'b0, 32'h0);
        check("late_c2_master_en", 64'(master_en), 64'd1);
        check("late_c2_nop", 64'(driver_data), 64'd0);
        check("late_c2_ready", 64'(req_ready), 64'd1);
        tick();
        drive(4'b0000, 1'b1, 32'h0);
        check("late_c3_master_en", 64'(master_en), 64'd1);
        check("late_c3_cmd", 64'(driver_data), 64'(cmds[0]));
        check("late_cfg_hold", 64'(driver_cfg), 64'd2);
        tick();
        drive(4'b0000, 1'b1, 32'h0);
        check("late_c4_master_en", 64'(master_en), 64'd1);
        tick();
        drive(4'b0000, 1'b0, 32'h0);
        check("late_c5_master_en", 64'(master_en), 64'd0);
        check("late_cfg_not_yet", 64'(driver_cfg), 64'd2);
        tick();
        drive(4'b0000, 1'b0, 32'h0);
        check("late_cfg_new", 64'(driver_cfg), 64'd1);
        tick();
        check_queues("late");

        // Reset with a read pending: outputs clear at once, no stray response.
        grant_q.push_back(2);
        cmdexp_q.push_back(cmds[2]);
        drive(4'b0100, 1'b0, 32'h0); tick();
        drive(4'b0000, 1'b1, 32'h0); tick();
        req_valid         = 4'b0001;
        driver_read       = 1'b1;
        spi_slv_read_data = 32'hCAFE_F00D;
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_master_en", 64'(master_en), 64'd0);
        check("mrst_driver_data", 64'(driver_data), 64'd0);
        check("mrst_driver_cfg", 64'(driver_cfg), 64'd0);
        check("mrst_req_ready", 64'(req_ready), 64'd0);
        check("mrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mrst_rsp_data", 64'(rsp_data), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        req_valid = '0;
        rst_n     = 1'b1;
        for (int j = 0; j < 3; j++) begin
            drive(4'b0000, 1'b1, 32'hBAD0_0000 + 32'(j));
            check($sformatf("mrst_after%0d_rsp_valid", j), 64'(rsp_valid), 64'd0);
            tick();
        end
        check_queues("mrst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
